genius_param: RTL and testbench

GENIUS_PARAM -- requirements
Module: genius_param

---
 rtl/genius_param.sv | 195 +++++++++++++++++++
 tb/tb_genius_param.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_param.sv
// Memory game ("Genius"): shows a growing random symbol sequence, then checks the player's replay.
// Optional macro GENIUS_INPUT_TIMEOUT_EN adds a WAIT_IN idle timeout that forces a loss.
module genius_param #(
   parameter int          NUM_BTN       = 3,
   parameter int          MAX_LEVEL     = 16,
   parameter int          SHOW_TICKS    = 4,
   parameter int          GAP_TICKS     = 2,
   parameter int          TIMEOUT_TICKS = 1000,
   parameter logic [15:0] SEED          = 16'hACE1,
   localparam int         VW            = (NUM_BTN > 2) ? $clog2(NUM_BTN) : 1,
   localparam int         LW            = $clog2(MAX_LEVEL + 1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [NUM_BTN-1:0] btn,
   output logic               show_valid,
   output logic [VW-1:0]      show_value,
   output logic [LW-1:0]      level,
   output logic [LW-1:0]      expect_idx,
   output logic [2:0]         state,
   output logic               game_won,
   output logic               game_over
);

   localparam int AW    = $clog2(MAX_LEVEL);
   localparam int TMAX  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
   localparam int CW    = $clog2(TMAX + 1);

   if (NUM_BTN < 2 || NUM_BTN > 8 || MAX_LEVEL < 2 || MAX_LEVEL > 64 || SEED == 16'h0000 ||
       SHOW_TICKS < 1 || GAP_TICKS < 1 || TIMEOUT_TICKS < 1) begin : g_param_err
      $error("genius_param: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADD      = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_OFF = 3'd3,
      S_WAIT_IN  = 3'd4,
      S_WIN      = 3'd5,
      S_LOSE     = 3'd6
   } state_e;

   state_e             state_q;
   logic [LW-1:0]      level_q;
   logic [LW-1:0]      idx_q;
   logic               valid_q;
   logic [VW-1:0]      value_q;
   logic               won_q;
   logic               over_q;
   logic [15:0]        lfsr_q;
   logic [15:0]        lfsr_d;
   logic [NUM_BTN-1:0] btn_q;
   logic [CW-1:0]      tick_q;
   logic [VW-1:0]      mem [MAX_LEVEL];

`ifdef GENIUS_INPUT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   logic [TW-1:0]      to_cnt_q;
`endif

   logic [VW-1:0]      rnd_raw;
   logic [VW-1:0]      rnd;
   logic [NUM_BTN-1:0] press;
   logic [VW-1:0]      exp_sym;
   logic [NUM_BTN-1:0] exp_oh;
   logic [VW-1:0]      first_sym;
   logic [VW-1:0]      next_sym;
   logic               last_elem;
   logic               more_show;

   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // Folding once is enough: 2^VW < 2*NUM_BTN, so the result is always a legal symbol.
   assign rnd_raw   = lfsr_q[VW-1:0];
   assign rnd       = (rnd_raw >= VW'(NUM_BTN)) ? rnd_raw - VW'(NUM_BTN) : rnd_raw;
   assign press     = btn & ~btn_q;
   assign exp_sym   = mem[idx_q[AW-1:0]];
   assign exp_oh    = NUM_BTN'(1) << exp_sym;
   assign last_elem = (idx_q == level_q - LW'(1));
   assign more_show = ((idx_q + LW'(1)) < level_q);
   assign next_sym  = mem[AW'(idx_q + LW'(1))];
   // When level is 0, mem[0] is being written this very clock, so bypass with the fresh symbol.
   assign first_sym = (level_q == '0) ? rnd : mem[0];

   always_ff @(posedge clock) begin
      if (state_q == S_ADD) mem[level_q[AW-1:0]] <= rnd;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         level_q  <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
         value_q  <= '0;
         won_q    <= 1'b0;
         over_q   <= 1'b0;
         lfsr_q   <= SEED;
         btn_q    <= '0;
         tick_q   <= '0;
`ifdef GENIUS_INPUT_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
      end else begin
         lfsr_q <= lfsr_d;
         btn_q  <= btn;
`ifdef GENIUS_INPUT_TIMEOUT_EN
         to_cnt_q <= '0;
`endif
         case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
               if (start) begin
                  level_q <= '0;
                  idx_q   <= '0;
                  won_q   <= 1'b0;
                  over_q  <= 1'b0;
                  state_q <= S_ADD;
               end
            end
            S_ADD: begin
               level_q <= level_q + LW'(1);
               idx_q   <= '0;
               tick_q  <= '0;
               valid_q <= 1'b1;
               value_q <= first_sym;
               state_q <= S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (tick_q == CW'(SHOW_TICKS - 1)) begin
                  tick_q  <= '0;
                  valid_q <= 1'b0;
                  value_q <= '0;
                  state_q <= S_SHOW_OFF;
               end else begin
                  tick_q <= tick_q + CW'(1);
               end
            end
            S_SHOW_OFF: begin
               if (tick_q == CW'(GAP_TICKS - 1)) begin
                  tick_q <= '0;
                  if (more_show) begin
                     idx_q   <= idx_q + LW'(1);
                     valid_q <= 1'b1;
                     value_q <= next_sym;
                     state_q <= S_SHOW_ON;
                  end else begin
                     idx_q   <= '0;
                     state_q <= S_WAIT_IN;
                  end
               end else begin
                  tick_q <= tick_q + CW'(1);
               end
            end
            S_WAIT_IN: begin
               if (press != '0) begin
                  if (press == exp_oh) begin
                     if (last_elem) begin
                        if (level_q == LW'(MAX_LEVEL)) begin
                           won_q   <= 1'b1;
                           state_q <= S_WIN;
                        end else begin
                           state_q <= S_ADD;
                        end
                     end else begin
                        idx_q <= idx_q + LW'(1);
                     end
                  end else begin
                     over_q  <= 1'b1;
                     state_q <= S_LOSE;
                  end
               end
`ifdef GENIUS_INPUT_TIMEOUT_EN
               else if (to_cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                  over_q  <= 1'b1;
                  state_q <= S_LOSE;
               end else begin
                  to_cnt_q <= to_cnt_q + TW'(1);
               end
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign show_valid = valid_q;
   assign show_value = value_q;
   assign level      = level_q;
   assign expect_idx = idx_q;
   assign state      = state_q;
   assign game_won   = won_q;
   assign game_over  = over_q;

endmodule

// File: tb/tb_genius_param.sv
// Bench for genius_param: scripted scenarios plus randomized games against a sequence-level model.
module tb_genius_param;

   localparam int NB = 3;
   localparam int ML = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] btn   = 3'b000;
   logic       show_valid;
   logic [1:0] show_value;
   logic [1:0] level;
   logic [1:0] expect_idx;
   logic [2:0] state;
   logic       game_won;
   logic       game_over;

   always #5 clock = ~clock;

   genius_param #(
      .NUM_BTN(NB), .MAX_LEVEL(ML), .SHOW_TICKS(2), .GAP_TICKS(1),
      .TIMEOUT_TICKS(20), .SEED(16'hACE1)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .btn(btn),
      .show_valid(show_valid), .show_value(show_value), .level(level),
      .expect_idx(expect_idx), .state(state), .game_won(game_won), .game_over(game_over)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int seq_m[$];
   int shown[$];
   int bad_lfsr = 0;
   int bad_rng  = 0;
   int cyc      = 0;
   int valid_cyc;
   bit show_to;

   task automatic start_pulse();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic press(input logic [2:0] b);
      @(negedge clock);
      btn = b;
      @(negedge clock);
      btn = 3'b000;
   endtask

   // Follows the display phase until WAIT_IN, recording each shown symbol once.
   task automatic run_show();
      logic pv;
      pv = 1'b0;
      shown.delete();
      valid_cyc = 0;
      show_to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         cyc++;
         if (dut.lfsr_q == 16'h0000) bad_lfsr++;
         if (show_valid ? (show_value >= 2'd3) : (show_value != 2'd0)) bad_rng++;
         if (show_valid) valid_cyc++;
         if (show_valid && !pv) shown.push_back(int'(show_value));
         pv = show_valid;
         if (state == 3'd4) begin
            show_to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({state, level, expect_idx, show_valid, show_value, game_won, game_over} !== 12'h000)
         $display("FAIL reset_outputs: got %h want 000",
                  {state, level, expect_idx, show_valid, show_value, game_won, game_over});
      else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_checks++;
      if (state !== 3'd0) $display("FAIL reset_idle: state %0d want 0", state);
      else n_pass++;
   endtask

   task automatic test_first_round();
      int v0;
      start_pulse();
      n_checks++;
      if (state !== 3'd1) $display("FAIL first_add: state %0d want 1", state);
      else n_pass++;
      @(negedge clock);
      v0 = int'(show_value);
      n_checks++;
      if ({state, show_valid} !== {3'd2, 1'b1} || v0 >= 3)
         $display("FAIL first_show_on: state %0d valid %0d value %0d want 2/1/<3", state, show_valid, v0);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if ({state, show_valid, show_value} !== {3'd2, 1'b1, 2'(v0)})
         $display("FAIL first_show_hold: state %0d valid %0d value %0d want 2/1/%0d", state, show_valid, show_value, v0);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if ({state, show_valid, show_value} !== {3'd3, 1'b0, 2'd0})
         $display("FAIL first_show_off: state %0d valid %0d value %0d want 3/0/0", state, show_valid, show_value);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if ({state, level, expect_idx} !== {3'd4, 2'd1, 2'd0})
         $display("FAIL first_wait: state %0d level %0d idx %0d want 4/1/0", state, level, expect_idx);
      else n_pass++;
      seq_m.delete();
      seq_m.push_back(v0);
   endtask

   task automatic test_win();
      int errs;
      for (int r = 1; r <= ML; r++) begin
         for (int i = 0; i < r; i++) begin
            press(3'(1 << seq_m[i]));
            n_checks++;
            if (i < r - 1) begin
               if ({state, expect_idx} !== {3'd4, 2'(i + 1)})
                  $display("FAIL win_step: state %0d idx %0d want 4/%0d", state, expect_idx, i + 1);
               else n_pass++;
            end else if (r < ML) begin
               if (state !== 3'd1) $display("FAIL win_round_add: state %0d want 1", state);
               else n_pass++;
            end else begin
               if ({state, game_won, level} !== {3'd5, 1'b1, 2'd3})
                  $display("FAIL win_final: state %0d won %0d level %0d want 5/1/3", state, game_won, level);
               else n_pass++;
            end
         end
         if (r < ML) begin
            run_show();
            errs = 0;
            for (int k = 0; k < r; k++) if (shown[k] != seq_m[k]) errs++;
            n_checks++;
            if (show_to || shown.size() != r + 1 || errs != 0 || shown[r] >= 3)
               $display("FAIL win_replay: timeout %0d shown %0d want %0d prefix_errs %0d", show_to, shown.size(), r + 1, errs);
            else n_pass++;
            n_checks++;
            if (level !== 2'(r + 1) || valid_cyc != 2 * (r + 1))
               $display("FAIL win_level: level %0d valid_cycles %0d want %0d/%0d", level, valid_cyc, r + 1, 2 * (r + 1));
            else n_pass++;
            seq_m.push_back(shown[r]);
         end
      end
      press(3'b001);
      n_checks++;
      if ({state, game_won} !== {3'd5, 1'b1}) $display("FAIL win_ignores_press: state %0d want 5", state);
      else n_pass++;
   endtask

   task automatic test_wrong();
      start_pulse();
      n_checks++;
      if ({state, game_won, game_over, level} !== {3'd1, 1'b0, 1'b0, 2'd0})
         $display("FAIL wrong_restart: state %0d won %0d over %0d level %0d want 1/0/0/0", state, game_won, game_over, level);
      else n_pass++;
      run_show();
      seq_m.delete();
      seq_m.push_back(shown[0]);
      press(3'(1 << seq_m[0]));
      n_checks++;
      if (state !== 3'd1) $display("FAIL wrong_round1: state %0d want 1", state);
      else n_pass++;
      run_show();
      n_checks++;
      if (show_to || level !== 2'd2 || shown[0] != seq_m[0])
         $display("FAIL wrong_round2_show: level %0d first %0d want 2/%0d", level, shown[0], seq_m[0]);
      else n_pass++;
      seq_m.push_back(shown[1]);
      press(3'(1 << seq_m[0]));
      n_checks++;
      if ({state, expect_idx} !== {3'd4, 2'd1}) $display("FAIL wrong_first_ok: state %0d idx %0d want 4/1", state, expect_idx);
      else n_pass++;
      press(3'(1 << ((seq_m[1] + 1) % 3)));
      n_checks++;
      if ({state, game_over, level} !== {3'd6, 1'b1, 2'd2})
         $display("FAIL wrong_lose: state %0d over %0d level %0d want 6/1/2", state, game_over, level);
      else n_pass++;
      start_pulse();
      n_checks++;
      if ({state, game_over, level} !== {3'd1, 1'b0, 2'd0})
         $display("FAIL wrong_newgame: state %0d over %0d level %0d want 1/0/0", state, game_over, level);
      else n_pass++;
      run_show();
      n_checks++;
      if (show_to || {state, level, expect_idx} !== {3'd4, 2'd1, 2'd0})
         $display("FAIL wrong_newgame_wait: state %0d level %0d idx %0d want 4/1/0", state, level, expect_idx);
      else n_pass++;
   endtask

   task automatic test_multi_press();
      press(3'b011);
      n_checks++;
      if ({state, game_over} !== {3'd6, 1'b1}) $display("FAIL multi_press: state %0d over %0d want 6/1", state, game_over);
      else n_pass++;
   endtask

   task automatic test_hold();
      int v;
      start_pulse();
      @(negedge clock);
      v = int'(show_value);
      btn = 3'(1 << v);
      for (int i = 0; i < 20 && state != 3'd4; i++) @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if ({state, expect_idx, level} !== {3'd4, 2'd0, 2'd1})
         $display("FAIL hold_no_press: state %0d idx %0d level %0d want 4/0/1", state, expect_idx, level);
      else n_pass++;
      btn = 3'b000;
      press(3'(1 << v));
      n_checks++;
      if (state !== 3'd1) $display("FAIL hold_then_press: state %0d want 1", state);
      else n_pass++;
      run_show();
      n_checks++;
      if (show_to || level !== 2'd2) $display("FAIL hold_round2: level %0d want 2", level);
      else n_pass++;
   endtask

   task automatic test_timeout();
`ifdef GENIUS_INPUT_TIMEOUT_EN
      repeat (19) @(negedge clock);
      n_checks++;
      if (state !== 3'd4) $display("FAIL timeout_early: state %0d want 4", state);
      else n_pass++;
      @(negedge clock);
      n_checks++;
      if ({state, game_over} !== {3'd6, 1'b1}) $display("FAIL timeout_lose: state %0d over %0d want 6/1", state, game_over);
      else n_pass++;
`else
      repeat (200) @(negedge clock);
      n_checks++;
      if ({state, expect_idx} !== {3'd4, 2'd0}) $display("FAIL no_timeout: state %0d idx %0d want 4/0", state, expect_idx);
      else n_pass++;
      press(3'b011);
      n_checks++;
      if (state !== 3'd6) $display("FAIL no_timeout_lose: state %0d want 6", state);
      else n_pass++;
`endif
   endtask

   task automatic test_random_games();
      int lvl, exp_s, errs;
      bit alive, wrong;
      logic [2:0] b;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      cyc = 0;
      bad_lfsr = 0;
      bad_rng = 0;
      for (int g = 0; g < 200 && cyc < 1000; g++) begin
         start_pulse();
         seq_m.delete();
         lvl = 0;
         alive = 1'b1;
         while (alive) begin
            run_show();
            errs = 0;
            for (int k = 0; k < lvl; k++) if (shown[k] != seq_m[k]) errs++;
            n_checks++;
            if (show_to || shown.size() != lvl + 1 || errs != 0 || shown[lvl] >= 3) begin
               $display("FAIL rand_show: game %0d timeout %0d shown %0d want %0d prefix_errs %0d", g, show_to, shown.size(), lvl + 1, errs);
               alive = 1'b0;
            end else n_pass++;
            if (!alive) break;
            seq_m.push_back(shown[lvl]);
            lvl++;
            n_checks++;
            if (level !== 2'(lvl)) $display("FAIL rand_level: level %0d want %0d", level, lvl);
            else n_pass++;
            for (int i = 0; i < lvl; i++) begin
               wrong = ($urandom_range(0, 7) == 0);
               if (!wrong) b = 3'(1 << seq_m[i]);
               else if ($urandom_range(0, 1) == 1) b = 3'b111 ^ 3'(1 << seq_m[i]);
               else b = 3'(1 << ((seq_m[i] + 1 + int'($urandom_range(0, 1))) % 3));
               press(b);
               cyc += 2;
               if (wrong) exp_s = 6;
               else if (i < lvl - 1) exp_s = 4;
               else if (lvl == ML) exp_s = 5;
               else exp_s = 1;
               n_checks++;
               if (state !== 3'(exp_s) || (exp_s == 4 && expect_idx !== 2'(i + 1)))
                  $display("FAIL rand_press: state %0d idx %0d want %0d/%0d", state, expect_idx, exp_s, i + 1);
               else n_pass++;
               if (exp_s != 4) begin
                  if (exp_s != 1) alive = 1'b0;
                  break;
               end
            end
         end
      end
      n_checks++;
      if (bad_lfsr != 0) $display("FAIL lfsr_nonzero: zero seen %0d times want 0", bad_lfsr);
      else n_pass++;
      n_checks++;
      if (bad_rng != 0) $display("FAIL show_range: bad values %0d want 0", bad_rng);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      start_pulse();
      @(negedge clock);
      n_checks++;
      if ({state, show_valid} !== {3'd2, 1'b1}) $display("FAIL mid_show_on: state %0d valid %0d want 2/1", state, show_valid);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({state, level, expect_idx, show_valid, show_value, game_won, game_over} !== 12'h000)
         $display("FAIL mid_reset_async: got %h want 000",
                  {state, level, expect_idx, show_valid, show_value, game_won, game_over});
      else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_checks++;
      if ({state, level} !== {3'd0, 2'd0}) $display("FAIL mid_reset_idle: state %0d level %0d want 0/0", state, level);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_win();
      test_wrong();
      test_multi_press();
      test_hold();
      test_timeout();
      test_random_games();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, %0d of %0d passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

endmodule
